// File: rtl/pcie_clk_pkg.sv
// Shared encodings for the PHY clock-tree sequencer: FSM states and divider phases.
package pcie_clk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    // Phase 7 drives every derived clock low; phase 0 is the common rising edge.
    localparam logic [2:0] PH_ALL_LOW  = 3'd7;
    localparam logic [2:0] PH_ALL_HIGH = 3'd0;

endpackage

// File: rtl/pcie_clk_div8.sv
// Three-bit phase counter producing the registered /2, /4, /8 clocks and frame strobe.
module pcie_clk_div8
    import pcie_clk_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_load,
    input  logic       i_inc,
    output logic [2:0] o_cnt,
    output logic       o_clk_4f,
    output logic       o_clk_2f,
    output logic       o_clk_f,
    output logic       o_frame_sync
);

    logic [2:0] r_cnt;
    logic [2:0] w_cnt_next;
    logic       r_clk_4f;
    logic       r_clk_2f;
    logic       r_clk_f;
    logic       r_frame_sync;

    always_comb begin
        w_cnt_next = r_cnt;
        if (i_load) begin
            w_cnt_next = PH_ALL_LOW;
        end else if (i_inc) begin
            w_cnt_next = r_cnt + 3'd1;
        end
    end

    // Outputs are registered from the next phase so they always track r_cnt;
    // while parked at PH_ALL_LOW every output is naturally low.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt        <= PH_ALL_LOW;
            r_clk_4f     <= 1'b0;
            r_clk_2f     <= 1'b0;
            r_clk_f      <= 1'b0;
            r_frame_sync <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_next;
            r_clk_4f     <= ~w_cnt_next[0];
            r_clk_2f     <= ~w_cnt_next[1];
            r_clk_f      <= ~w_cnt_next[2];
            r_frame_sync <= (w_cnt_next == PH_ALL_HIGH);
        end
    end

    assign o_cnt        = r_cnt;
    assign o_clk_4f     = r_clk_4f;
    assign o_clk_2f     = r_clk_2f;
    assign o_clk_f      = r_clk_f;
    assign o_frame_sync = r_frame_sync;

endmodule

// File: rtl/pcie_clk_seq.sv
// PHY clock-tree sequencer: warm-up hold, glitch-free start/stop of the f/2f/4f
// clocks, lock qualification (clk_valid) and frame-sync strobe.
module pcie_clk_seq
    import pcie_clk_pkg::*;
#(
    parameter int WARMUP_CYC   = 16,
    parameter int LOCK_PERIODS = 2,
    parameter int WCNT_W       = 5
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       enable,
    output logic       clk_out_4f,
    output logic       clk_out_2f,
    output logic       clk_out_f,
    output logic       frame_sync,
    output logic       clk_valid,
    output logic [1:0] state_o
);

    localparam logic [WCNT_W-1:0] WARM_LAST = WCNT_W'(WARMUP_CYC - 1);
    localparam logic [WCNT_W-1:0] LOCK_VAL  = WCNT_W'(LOCK_PERIODS);
    localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);

    state_t            r_state;
    state_t            w_state_next;
    logic [WCNT_W-1:0] r_wcnt;
    logic [WCNT_W-1:0] w_wcnt_next;
    logic              r_clk_valid;
    logic              w_valid_next;
    logic              r_run_q;
    logic              w_load;
    logic              w_inc;
    logic [2:0]        w_cnt;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_wcnt      <= '0;
            r_clk_valid <= 1'b0;
            r_run_q     <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_wcnt      <= w_wcnt_next;
            r_clk_valid <= w_valid_next;
            r_run_q     <= (r_state == ST_RUN);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_wcnt_next  = r_wcnt;
        w_valid_next = r_clk_valid;
        w_load       = 1'b0;
        w_inc        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_load       = 1'b1;
                w_wcnt_next  = '0;
                w_valid_next = 1'b0;
                if (enable) begin
                    w_state_next = ST_WARMUP;
                end
            end
            ST_WARMUP: begin
                w_load       = 1'b1;
                w_valid_next = 1'b0;
                if (!enable) begin
                    w_state_next = ST_IDLE;
                    w_wcnt_next  = '0;
                end else if (r_wcnt == WARM_LAST) begin
                    w_state_next = ST_RUN;
                    w_wcnt_next  = '0;
                end else begin
                    w_wcnt_next = r_wcnt + WCNT_ONE;
                end
            end
            ST_RUN: begin
                w_inc = 1'b1;
                // The phase-7 cycle on RUN entry precedes the first edge, so only
                // phase-7 cycles after a full period (r_run_q) count as completed.
                if (!enable) begin
                    w_state_next = ST_DRAIN;
                    w_wcnt_next  = '0;
                    w_valid_next = 1'b0;
                end else if (w_cnt == PH_ALL_LOW && r_run_q && r_wcnt != LOCK_VAL) begin
                    w_wcnt_next  = r_wcnt + WCNT_ONE;
                    w_valid_next = ((r_wcnt + WCNT_ONE) == LOCK_VAL);
                end
            end
            ST_DRAIN: begin
                w_wcnt_next  = '0;
                w_valid_next = 1'b0;
                if (w_cnt == PH_ALL_LOW) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_inc = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_wcnt_next  = '0;
                w_valid_next = 1'b0;
                w_load       = 1'b1;
            end
        endcase
    end

    pcie_clk_div8 u_div8 (
        .i_clk        (clk_in),
        .i_reset      (reset),
        .i_load       (w_load),
        .i_inc        (w_inc),
        .o_cnt        (w_cnt),
        .o_clk_4f     (clk_out_4f),
        .o_clk_2f     (clk_out_2f),
        .o_clk_f      (clk_out_f),
        .o_frame_sync (frame_sync)
    );

    assign clk_valid = r_clk_valid;
    assign state_o   = r_state;

endmodule

// File: tb/tb_pcie_clk_seq.sv
// Directed bench for pcie_clk_seq: reset, start-up timing, shutdown drain,
// warm-up abort, re-enable during drain and mid-run reset.
module tb_pcie_clk_seq;

    logic       clk_in = 1'b0;
    logic       reset;
    logic       enable;
    logic       clk_out_4f;
    logic       clk_out_2f;
    logic       clk_out_f;
    logic       frame_sync;
    logic       clk_valid;
    logic [1:0] state_o;
    logic [3:0] obs;

    int n_checks = 0;
    int n_errors = 0;
    logic [5:0] exp_q[$];

    always #5 clk_in = ~clk_in;

    pcie_clk_seq #(
        .WARMUP_CYC   (16),
        .LOCK_PERIODS (2),
        .WCNT_W       (5)
    ) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .enable     (enable),
        .clk_out_4f (clk_out_4f),
        .clk_out_2f (clk_out_2f),
        .clk_out_f  (clk_out_f),
        .frame_sync (frame_sync),
        .clk_valid  (clk_valid),
        .state_o    (state_o)
    );

    assign obs = {clk_out_4f, clk_out_2f, clk_out_f, frame_sync};

    // Expected {4f, 2f, f, frame_sync} for a given phase: /2, /4, /8 clocks all high at phase 0.
    function automatic logic [3:0] exp_clk(input int c);
        logic [2:0] p;
        p = 3'(c % 8);
        return {~p[0], ~p[1], ~p[2], (p == 3'd0)};
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({obs, clk_valid} !== 5'b0 || state_o !== 2'd0) begin
                n_errors++;
                $display("FAIL reset_hold[%0d]: outs=%b valid=%b state=%0d, required outs=0000 valid=0 state=0",
                         i, obs, clk_valid, state_o);
            end
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (state_o !== 2'd1) begin
            n_errors++;
            $display("FAIL reset_release: state=%0d, required 1", state_o);
        end
        enable = 1'b0;
        tick();
        n_checks++;
        if (state_o !== 2'd0 || obs !== 4'b0) begin
            n_errors++;
            $display("FAIL one_cycle_enable: state=%0d outs=%b, required state=0 outs=0000", state_o, obs);
        end
    endtask

    task automatic test_startup();
        enable = 1'b1;
        for (int t = 1; t <= 17; t++) begin
            tick();
            n_checks++;
            if (obs !== 4'b0 || clk_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL warmup_quiet[t=%0d]: outs=%b valid=%b, required 0000/0", t, obs, clk_valid);
            end
            if (t == 1) begin
                n_checks++;
                if (state_o !== 2'd1) begin
                    n_errors++;
                    $display("FAIL warmup_entry: state=%0d, required 1", state_o);
                end
            end
            if (t == 17) begin
                n_checks++;
                if (state_o !== 2'd2) begin
                    n_errors++;
                    $display("FAIL run_entry: state=%0d, required 2", state_o);
                end
            end
        end
        // j counts cycles from the first common rising edge (18 cycles after enable).
        for (int j = 0; j <= 26; j++) begin
            tick();
            n_checks++;
            if (obs !== exp_clk(j) || state_o !== 2'd2) begin
                n_errors++;
                $display("FAIL run_clocks[j=%0d]: outs=%b state=%0d, required outs=%b state=2",
                         j, obs, state_o, exp_clk(j));
            end
            n_checks++;
            if (clk_valid !== (j >= 16)) begin
                n_errors++;
                $display("FAIL lock_valid[j=%0d]: valid=%b, required %b", j, clk_valid, (j >= 16));
            end
        end
    endtask

    task automatic test_shutdown();
        // Entered with phase 2 on the outputs; enable drops in this cycle.
        enable = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (k <= 5) exp_q.push_back({2'd3, exp_clk(2 + k)});
            else        exp_q.push_back({2'd0, 4'b0000});
        end
        for (int k = 1; k <= 8; k++) begin
            logic [5:0] e;
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if ({state_o, obs} !== e) begin
                n_errors++;
                $display("FAIL drain_seq[k=%0d]: state=%0d outs=%b, required state=%0d outs=%b",
                         k, state_o, obs, e[5:4], e[3:0]);
            end
            n_checks++;
            if (clk_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL drain_valid[k=%0d]: valid=%b, required 0", k, clk_valid);
            end
        end
    endtask

    task automatic test_abort_warmup();
        enable = 1'b1;
        for (int t = 1; t <= 5; t++) begin
            tick();
            n_checks++;
            if (state_o !== 2'd1 || obs !== 4'b0) begin
                n_errors++;
                $display("FAIL abort_warmup[t=%0d]: state=%0d outs=%b, required state=1 outs=0000", t, state_o, obs);
            end
        end
        enable = 1'b0;
        for (int t = 1; t <= 3; t++) begin
            tick();
            n_checks++;
            if (state_o !== 2'd0 || obs !== 4'b0) begin
                n_errors++;
                $display("FAIL abort_idle[t=%0d]: state=%0d outs=%b, required state=0 outs=0000", t, state_o, obs);
            end
        end
        enable = 1'b1;
        for (int t = 1; t <= 18; t++) begin
            tick();
            if (t < 18) begin
                n_checks++;
                if (obs !== 4'b0) begin
                    n_errors++;
                    $display("FAIL rewarm_quiet[t=%0d]: outs=%b, required 0000", t, obs);
                end
            end else begin
                n_checks++;
                if (obs !== 4'b1111 || state_o !== 2'd2) begin
                    n_errors++;
                    $display("FAIL rewarm_first_edge: outs=%b state=%0d, required outs=1111 state=2", obs, state_o);
                end
            end
        end
    endtask

    task automatic test_drain_reenable();
        // Entered at phase 0 (all clocks high).
        enable = 1'b0;
        for (int k = 1; k <= 26; k++) begin
            tick();
            if (k <= 7) begin
                n_checks++;
                if (state_o !== 2'd3 || obs !== exp_clk(k)) begin
                    n_errors++;
                    $display("FAIL reen_drain[k=%0d]: state=%0d outs=%b, required state=3 outs=%b",
                             k, state_o, obs, exp_clk(k));
                end
            end else if (k < 26) begin
                n_checks++;
                if (obs !== 4'b0 || clk_valid !== 1'b0) begin
                    n_errors++;
                    $display("FAIL reen_quiet[k=%0d]: outs=%b valid=%b, required 0000/0", k, obs, clk_valid);
                end
            end else begin
                n_checks++;
                if (obs !== 4'b1111) begin
                    n_errors++;
                    $display("FAIL reen_first_edge: outs=%b, required 1111", obs);
                end
            end
            if (k == 8) begin
                n_checks++;
                if (state_o !== 2'd0) begin
                    n_errors++;
                    $display("FAIL reen_idle: state=%0d, required 0", state_o);
                end
            end
            if (k == 9) begin
                n_checks++;
                if (state_o !== 2'd1) begin
                    n_errors++;
                    $display("FAIL reen_warmup: state=%0d, required 1", state_o);
                end
            end
            if (k == 2) enable = 1'b1;
        end
    endtask

    task automatic test_midrun_reset();
        for (int j = 1; j <= 16; j++) tick();
        n_checks++;
        if (clk_valid !== 1'b1 || clk_out_f !== 1'b1 || state_o !== 2'd2) begin
            n_errors++;
            $display("FAIL pre_reset_run: valid=%b f=%b state=%0d, required valid=1 f=1 state=2",
                     clk_valid, clk_out_f, state_o);
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if ({obs, clk_valid} !== 5'b0 || state_o !== 2'd0) begin
            n_errors++;
            $display("FAIL midrun_reset: outs=%b valid=%b state=%0d, required outs=0000 valid=0 state=0",
                     obs, clk_valid, state_o);
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (state_o !== 2'd1 || obs !== 4'b0) begin
            n_errors++;
            $display("FAIL post_reset_warmup: state=%0d outs=%b, required state=1 outs=0000", state_o, obs);
        end
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        test_reset();
        test_startup();
        test_shutdown();
        test_abort_warmup();
        test_drain_reenable();
        test_midrun_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pcie_clk_seq.md
Name: pcie_clk_seq

Overview:
- Sequencing controller for the PHY clock tree. Takes the fast reference clock clk_in and generates phase-aligned clk_out_4f, clk_out_2f and clk_out_f (clk_in/2, /4, /8) from one counter.
- Owns start-up and shutdown. Provides a warm-up hold, glitch-free start and stop, a frame-sync strobe and a clocks-valid flag.
- Consumed by the serializer, deserializer and byte-striping blocks that run on the f/2f/4f domains.

Parameters:
- WARMUP_CYC, 16, clk_in cycles held in WARMUP with all outputs low before clocks start (≥1).
- LOCK_PERIODS, 2, complete clk_out_f periods in RUN before clk_valid asserts (≥1).
- WCNT_W, 5, width of the warm-up/lock counter; must hold max(WARMUP_CYC, LOCK_PERIODS).

Ports:
- clk_in  input  1  fast reference clock; all logic on its posedge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  level request to run the derived clocks.
- clk_out_4f  output  1  clk_in/2, 50% duty.
- clk_out_2f  output  1  clk_in/4, 50% duty.
- clk_out_f  output  1  clk_in/8, 50% duty.
- frame_sync  output  1  one-cycle pulse on the clk_in cycle where all three derived clocks rise together.
- clk_valid  output  1  derived clocks stable and usable.
- state_o  output  2  current FSM state: 0 IDLE, 1 WARMUP, 2 RUN, 3 DRAIN.

Behaviour:
- Single clock clk_in; reset is synchronous, active-high; everything updates on posedge clk_in.
- All outputs are registered. No combinational path from any input to any output.
- Reset: state IDLE, phase counter cnt[2:0]=7, wcnt=0, all outputs 0.
- Reset asserted mid-operation forces the reset values at the next edge, regardless of state.
- Derived clocks while state is RUN or DRAIN:
  - clk_out_4f = ~cnt[0], clk_out_2f = ~cnt[1], clk_out_f = ~cnt[2].
  - cnt increments mod 8 every cycle.
  - At cnt=7 all three are low; at cnt=0 all three are high, so rising edges coincide.
- In IDLE and WARMUP all derived clocks are held 0 and cnt is held at 7.
- frame_sync = 1 exactly in cycles where cnt=0 and state is RUN or DRAIN.
- FSM:
  - IDLE: enable=1 -> WARMUP with wcnt=0.
  - WARMUP: wcnt increments each cycle.
    - enable=0 -> IDLE, wcnt cleared.
    - wcnt=WARMUP_CYC-1 -> RUN with cnt=7, so the first derived-clock rising edge is 1 cycle after entering RUN.
    - wcnt is cleared on exit.
  - RUN: wcnt counts completed f periods (increment when cnt=7), saturating at LOCK_PERIODS.
    - clk_valid is set in the cycle wcnt reaches LOCK_PERIODS.
    - enable=0 -> DRAIN, and clk_valid clears in the same cycle.
  - DRAIN: clocks keep toggling until cnt=7 (all low), then -> IDLE with cnt held at 7.
    - Every output stops low; no truncated high phase.
    - enable re-asserted during DRAIN is ignored until IDLE is reached.
- Clock counts from enable=1 in IDLE:
  - State is WARMUP 1 cycle after enable.
  - First rising edge of all derived clocks comes WARMUP_CYC+2 cycles after enable.
  - clk_valid asserts LOCK_PERIODS*8 cycles after that first edge.
- Enable pulses shorter than 1 cycle in IDLE are not filtered; a 1-cycle enable enters WARMUP and then returns to IDLE.

Decomposition:
- Package pcie_clk_pkg holds:
  - state encoding constants ST_IDLE=0, ST_WARMUP=1, ST_RUN=2, ST_DRAIN=3;
  - phase constants PH_ALL_LOW=7, PH_ALL_HIGH=0.
- One natural sub-module, pcie_clk_div8: 3-bit phase counter with load-to-7/hold/increment controls, driving the three registered clock outputs and frame_sync.
- The FSM and wcnt stay in the top.

Test Plan:
- Reset: hold reset 3 cycles with enable=1 -> all outputs 0, state_o=0; after release state_o=1 on the next edge.
- Start-up (WARMUP_CYC=16, LOCK_PERIODS=2), enable=1 from IDLE:
  - first rising edge on clk_out_4f/2f/f comes 18 cycles after enable, all simultaneous, with frame_sync=1 on that cycle;
  - periods measure 2, 4 and 8 clk_in cycles;
  - clk_valid rises 16 cycles after the first edge.
- Shutdown: drop enable while cnt=2 -> clk_valid=0 next cycle; clocks toggle until cnt=7, then stay 0; state_o reaches 0; no high pulse shorter than half-period.
- Abort warm-up: enable=1 for 5 cycles, then 0 -> state returns to IDLE with no clock edges; re-enable gives the full 16-cycle warm-up again.
- Re-enable during DRAIN: enable 0→1 two cycles into DRAIN -> drain completes to IDLE, then WARMUP restarts; no clock activity in between.
- Mid-RUN reset: assert reset while clk_out_f=1 -> all outputs 0 at the next edge, state_o=0; clk_valid=0.
